// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit:
// state encodings, opcode values, ALUop codes, datapath mux selectors
// and the packed control-strobe bundle passed from the output decoder
// to the FSM top.
package ctrl_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned ALUSRCB_W = 2;
    localparam int unsigned PCSRC_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_LW    = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SW    = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_J     = 4'd6;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [ALUSRCB_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [ALUSRCB_W-1:0] SRCB_TWO    = 2'b01;
    localparam logic [ALUSRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [ALUSRCB_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic                 pc_write;
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 ir_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic                 reg_dst;
        logic                 alu_src_a;
        logic [ALUSRCB_W-1:0] alu_src_b;
        logic [ALUOP_W-1:0]   alu_op;
        logic [PCSRC_W-1:0]   pc_source;
    } ctrl_t;

endpackage : ctrl_pkg

// File: rtl/ctrl_output_decode.sv
// Combinational datapath-strobe decoder for the control FSM.
// Optional macro: ILLEGAL_OPCODE_TRAP_EN adds the illegal_op output.
// Ports:
//   state      in   current FSM state
//   op         in   opcode latched in DECODE
//   zero       in   ALU zero flag (branch resolution)
//   mem_ready  in   memory access completes this cycle (fetch qualify)
//   ctrl       out  packed strobe bundle
//   illegal_op out  high in TRAP (only with ILLEGAL_OPCODE_TRAP_EN)
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_t              state,
    input  logic [OPCODE_W-1:0] op,
    input  logic                zero,
    input  logic                mem_ready,
`ifdef ILLEGAL_OPCODE_TRAP_EN
    output logic                illegal_op,
`endif
    output ctrl_t               ctrl
);

    // Strobe decode; every field defaults to 0 (add, PC/ALU selectors).
    always_comb begin
        ctrl = '0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_TWO;
                // PC+2 and IR load only once the instruction word arrives.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                // Latched opcode is BEQ or BNE here; BNE takes on non-zero.
                ctrl.pc_write  = (op == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule : ctrl_output_decode

// File: rtl/main_control_fsm.sv
// Multicycle control FSM of the 16-bit processor: sequences each
// instruction through fetch/decode/execute/memory/writeback and drives
// the datapath strobes and ALUop.
// Optional macro: ILLEGAL_OPCODE_TRAP_EN sends illegal opcodes to a
// sticky TRAP state and adds the illegal_op output; otherwise illegal
// opcodes execute as a NOP.
// Ports:
//   clk, reset   clock (rising edge), async active-high reset
//   opcode       IR opcode field; sampled only in DECODE
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   pc_write .. pc_source   datapath strobes (combinational from state)
//   illegal_op   trap indicator (only with ILLEGAL_OPCODE_TRAP_EN)
//   state_dbg    current state encoding
module main_control_fsm
    import ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 alu_src_a,
    output logic [ALUSRCB_W-1:0] alu_src_b,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic [PCSRC_W-1:0]   pc_source,
`ifdef ILLEGAL_OPCODE_TRAP_EN
    output logic                 illegal_op,
`endif
    output logic [STATE_W-1:0]   state_dbg
);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    ctrl_t               ctrl_dec;
    ctrl_t               ctrl_out;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic                illegal_dec;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode captured in DECODE so later states ignore IR changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ITYPE:      state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:       state_d = S_TRAP;
`else
                    default:       state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   state_d = S_FETCH;
            S_MEM_ADDR: begin
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_q == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state      (state_q),
        .op         (op_q),
        .zero       (zero),
        .mem_ready  (mem_ready),
`ifdef ILLEGAL_OPCODE_TRAP_EN
        .illegal_op (illegal_dec),
`endif
        .ctrl       (ctrl_dec)
    );

    // Output logic: strobes are blanked while reset is held so a reset
    // landing mid-instruction cannot leak a write.
    always_comb begin
        ctrl_out = '0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        illegal_op = 1'b0;
`endif
        if (!reset) begin
            ctrl_out = ctrl_dec;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            illegal_op = illegal_dec;
`endif
        end
    end

    assign pc_write   = ctrl_out.pc_write;
    assign iord       = ctrl_out.iord;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign ir_write   = ctrl_out.ir_write;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign reg_write  = ctrl_out.reg_write;
    assign reg_dst    = ctrl_out.reg_dst;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_op     = ctrl_out.alu_op;
    assign pc_source  = ctrl_out.pc_source;
    assign state_dbg  = STATE_W'(state_q);

endmodule : main_control_fsm

// File: tb/tb_main_control_fsm.sv
// Directed self-checking bench for main_control_fsm.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_main_control_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic       illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
`ifdef ILLEGAL_OPCODE_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] all_outs();
        return {pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    function automatic logic [3:0] writes();
        return {pc_write, mem_write, ir_write, reg_write};
    endfunction

    // One cycle: drive inputs at the falling edge, settle, check state.
    task automatic step(input logic [3:0] op, input logic z, input logic mr, input int exp_st);
        @(negedge clk);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        #1;
        chk("state", 32'(state_dbg), exp_st);
        chk("rd_wr_excl", 32'(mem_read & mem_write), 0);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 4'd2;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset state: FETCH, every strobe blanked.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_outs", 32'(all_outs()), 0);

        // LW into MEM_RD stall, then reset mid-instruction.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(state_dbg), 0);
        chk("rel_mem_read", 32'(mem_read), 1);
        step(4'd2, 1'b0, 1'b1, 1);
        step(4'd2, 1'b0, 1'b1, 6);
        step(4'd2, 1'b0, 1'b0, 7);
        chk("mrd_mem_read", 32'(mem_read), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_state", 32'(state_dbg), 0);
        chk("midrst_outs", 32'(all_outs()), 0);
        @(negedge clk);
        #1;
        chk("midrst_hold", 32'(all_outs()), 0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        // First cycle after release: FETCH stalled on memory.
        chk("fstall_state", 32'(state_dbg), 0);
        chk("fstall_mem_read", 32'(mem_read), 1);
        chk("fstall_writes", 32'(writes()), 0);

        // R-type: 0,1,2,3 then back to FETCH.
        step(4'd0, 1'b0, 1'b1, 0);
        chk("r_fetch_pcw_irw", 32'({pc_write, ir_write}), 3);
        chk("r_fetch_srcb", 32'(alu_src_b), 1);
        step(4'd0, 1'b0, 1'b1, 1);
        chk("r_dec_srcb", 32'(alu_src_b), 3);
        step(4'd0, 1'b0, 1'b1, 2);
        chk("r_exec_aluop", 32'(alu_op), 2);
        chk("r_exec_regw", 32'(reg_write), 0);
        step(4'd0, 1'b0, 1'b1, 3);
        chk("r_wb_regw_dst", 32'({reg_write, reg_dst, mem_to_reg}), 6);

        // I-type: 0,1,4,5.
        step(4'd1, 1'b0, 1'b1, 0);
        step(4'd1, 1'b0, 1'b1, 1);
        step(4'd1, 1'b0, 1'b1, 4);
        chk("i_exec_aluop", 32'(alu_op), 3);
        chk("i_exec_srcb", 32'(alu_src_b), 2);
        step(4'd1, 1'b0, 1'b1, 5);
        chk("i_wb_regw_dst", 32'({reg_write, reg_dst}), 2);

        // LW with 3 stall cycles; IR changes to SW in MEM_ADDR are ignored.
        step(4'd2, 1'b0, 1'b1, 0);
        step(4'd2, 1'b0, 1'b1, 1);
        step(4'd3, 1'b0, 1'b1, 6);
        for (int i = 0; i < 3; i++) begin
            step(4'd3, 1'b0, 1'b0, 7);
            chk("lw_rd_strobes", 32'({mem_read, iord, mem_write}), 6);
        end
        step(4'd3, 1'b0, 1'b1, 7);
        step(4'd3, 1'b0, 1'b1, 8);
        chk("lw_wb", 32'({mem_to_reg, reg_write, reg_dst}), 6);

        // SW: 0,1,6,9.
        step(4'd3, 1'b0, 1'b1, 0);
        step(4'd3, 1'b0, 1'b1, 1);
        step(4'd3, 1'b0, 1'b1, 6);
        step(4'd3, 1'b0, 1'b1, 9);
        chk("sw_wr_strobes", 32'({mem_write, iord, mem_read}), 6);

        // BEQ taken; IR switches to BNE during BRANCH.
        step(4'd4, 1'b1, 1'b1, 0);
        step(4'd4, 1'b1, 1'b1, 1);
        step(4'd5, 1'b1, 1'b1, 10);
        chk("beq_pcw", 32'(pc_write), 1);
        chk("beq_aluop", 32'(alu_op), 1);
        chk("beq_pcsrc", 32'(pc_source), 1);

        // BNE with zero=1 not taken, zero=0 taken.
        step(4'd5, 1'b1, 1'b1, 0);
        step(4'd5, 1'b1, 1'b1, 1);
        step(4'd5, 1'b1, 1'b1, 10);
        chk("bne_z1_pcw", 32'(pc_write), 0);
        step(4'd5, 1'b0, 1'b1, 0);
        step(4'd5, 1'b0, 1'b1, 1);
        step(4'd5, 1'b0, 1'b1, 10);
        chk("bne_z0_pcw", 32'(pc_write), 1);

        // Jump: 0,1,11.
        step(4'd6, 1'b0, 1'b1, 0);
        step(4'd6, 1'b0, 1'b1, 1);
        step(4'd6, 1'b0, 1'b1, 11);
        chk("j_pcsrc_pcw", 32'({pc_source, pc_write}), 5);

        // Illegal opcode 9.
        step(4'd9, 1'b0, 1'b1, 0);
        step(4'd9, 1'b0, 1'b1, 1);
        chk("ill_dec_writes", 32'(writes()), 0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 1'b0, 1'b1, 12);
            chk("trap_illegal_op", 32'(illegal_op), 1);
            chk("trap_outs", 32'(all_outs()), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("trap_exit_state", 32'(state_dbg), 0);
        chk("trap_exit_ill", 32'(illegal_op), 0);
`else
        step(4'd9, 1'b0, 1'b1, 0);
        chk("ill_nop_fetch", 32'(mem_read), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_main_control_fsm
